vote_cu_param: RTL and testbench
================================

VOTE_CU_PARAM -- requirements
Module: vote_cu_param

Interface
REQ-001 Parameter N_CAND, default 15, number of candidates, legal range 2..15.
REQ-002 Parameter CNT_W, default 12, width of every vote counter and of out.
REQ-003 Parameter ID_W, default 4, candidate-code width; SHALL satisfy 2^ID_W > N_CAND.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Power_n  input  1  asynchronous, active-low reset.
REQ-006 Close  input  1  level; ends polling.
REQ-007 Clear  input  1  level; erases all tallies.
REQ-008 Ballot  input  1  level; arms exactly one vote.
REQ-009 Total  input  1  level; display the total vote count.
REQ-010 Result  input  1  each rising edge steps the per-candidate readout.
REQ-011 IN  input  ID_W  candidate code; 0 = no selection, 1..N_CAND valid.
REQ-012 out  output  CNT_W  displayed count, registered.
REQ-013 out_valid  output  1  out carries a count.
REQ-014 out_idx  output  ID_W  candidate code shown on out, or 0.
REQ-015 vote_ack  output  1  one-cycle pulse on an accepted vote.
REQ-016 reject  output  1  one-cycle pulse on an out-of-range code.
REQ-017 winner  output  ID_W  winning candidate code; 0 while unknown.
REQ-018 tie  output  1  two or more candidates share the maximum count.
REQ-019 winner_valid  output  1  winner and tie are final.

Function
REQ-020 States SHALL be IDLE, ARMED, TOTAL, CLOSED, RESULT, CLEAR.
REQ-021 IDLE priority: Clear->CLEAR, else Close->CLOSED, else Ballot->ARMED, else Total->TOTAL, else stay.
REQ-022 ARMED: Clear->CLEAR; else Close->CLOSED with no count; else IN in 1..N_CAND -> cnt[IN], total +1, vote_ack pulse, ->IDLE.
REQ-023 ARMED with IN > N_CAND: reject pulse, no count, remain ARMED; IN = 0: remain ARMED.
REQ-024 A held Ballot SHALL NOT re-arm until Ballot has been low for at least one cycle in IDLE.
REQ-025 Counters SHALL saturate at 2^CNT_W-1; total saturates independently.
REQ-026 TOTAL: out = total, out_valid = 1, out_idx = 0; ->IDLE when Total low; Clear takes priority.
REQ-027 CLOSED: Ballot ignored; winner scan starts on entry, N_CAND cycles, compares cnt[1..N_CAND] in ascending order.
REQ-028 winner = lowest code holding the maximum; tie = 1 if any other code equals it; all-zero tallies give winner = 1, tie = 1.
REQ-029 winner_valid SHALL assert exactly N_CAND+1 cycles after CLOSED entry and hold until CLEAR.
REQ-030 CLOSED: Result rising edge -> RESULT with out_idx = 1; Clear->CLEAR.
REQ-031 RESULT: out = cnt[out_idx], out_valid = 1, one cycle after the edge; each further Result rising edge increments out_idx, wrapping N_CAND->1.
REQ-032 RESULT: Close low or high has no effect; only Clear exits (->CLEAR).
REQ-033 CLEAR: zero all counters, total, winner, tie, winner_valid, out, out_idx; remain while Clear high; ->IDLE when low.
REQ-034 Outside TOTAL and RESULT, out = 0, out_valid = 0, out_idx = 0.
REQ-035 Simultaneous Clear and any other input: Clear wins in every state.

Reset
REQ-036 Power_n low SHALL asynchronously force IDLE, all counters 0, all outputs 0, Result edge detector and Ballot re-arm lock cleared.
REQ-037 Reset mid-scan or mid-vote SHALL discard the operation; no partial count survives.

Structure
REQ-038 Package vote_pkg SHALL hold the state enumeration and default N_CAND, CNT_W, ID_W.
REQ-039 Winner scan SHALL be sub-module vote_winner_scan (start, cnt array in, winner, tie, done).

Verification
REQ-040 Reset; Ballot, IN=3 -> vote_ack one cycle, cnt[3]=1, Total shows out=1.
REQ-041 Ballot, IN=15 with N_CAND=10 -> reject pulse, no count; then IN=2 -> accepted.
REQ-042 CNT_W=2; five votes for code 1 -> cnt[1]=3, total=3 (saturated).
REQ-043 Votes 2,2,5,5; Close -> winner_valid after N_CAND+1 cycles, winner=2, tie=1.
REQ-044 Closed; Result pulsed N_CAND+1 times -> out_idx 1..N_CAND then 1, out matches tallies.
REQ-045 Clear asserted during ARMED with IN=4 -> no count, CLEAR, all outputs 0, IDLE after Clear low.

Source files
------------

// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared defaults and FSM state codes for the voting control unit
package vote_pkg;

    localparam int DEF_N_CAND = 15;
    localparam int DEF_CNT_W  = 12;
    localparam int DEF_ID_W   = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARMED  = 3'd1;
    localparam logic [2:0] S_TOTAL  = 3'd2;
    localparam logic [2:0] S_CLOSED = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;
    localparam logic [2:0] S_CLEAR  = 3'd5;

endpackage

// File: rtl/vote_cu_param_if.sv
// rtl/vote_cu_param_if.sv - panel controls and display/status bundle of the voting unit
interface vote_cu_param_if
    import vote_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int ID_W  = DEF_ID_W
);
    logic             Close;
    logic             Clear;
    logic             Ballot;
    logic             Total;
    logic             Result;
    logic [ID_W-1:0]  IN;
    logic [CNT_W-1:0] out;
    logic             out_valid;
    logic [ID_W-1:0]  out_idx;
    logic             vote_ack;
    logic             reject;
    logic [ID_W-1:0]  winner;
    logic             tie;
    logic             winner_valid;

    modport master (
        output Close, Clear, Ballot, Total, Result, IN,
        input  out, out_valid, out_idx, vote_ack, reject, winner, tie, winner_valid
    );

    modport slave (
        input  Close, Clear, Ballot, Total, Result, IN,
        output out, out_valid, out_idx, vote_ack, reject, winner, tie, winner_valid
    );
endinterface

// File: rtl/vote_winner_scan.sv
// rtl/vote_winner_scan.sv - sequential max/tie scan over the candidate tallies
module vote_winner_scan
    import vote_pkg::*;
#(
    parameter int N_CAND = DEF_N_CAND,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ID_W   = DEF_ID_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic [N_CAND-1:0][CNT_W-1:0] cnt_i,
    output logic [ID_W-1:0]              winner_o,
    output logic                         tie_o,
    output logic                         done_o
);
    localparam logic [ID_W-1:0] LAST = ID_W'(N_CAND);
    localparam logic [ID_W-1:0] ONE  = ID_W'(1);

    logic             busy_q, busy_d;
    logic             fin_q, fin_d;
    logic [ID_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [ID_W-1:0]  best_q, best_d;
    logic             tie_run_q, tie_run_d;
    logic [ID_W-1:0]  winner_q, winner_d;
    logic             tie_q, tie_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cur;

    // Tally of the candidate currently under inspection
    always_comb begin
        cur = '0;
        for (int k = 0; k < N_CAND; k++) begin
            if (idx_q == ID_W'(k + 1)) cur = cnt_i[k];
        end
    end

    // One candidate per cycle; strict '>' keeps the lowest code on equal maxima
    always_comb begin
        busy_d    = busy_q;
        fin_d     = 1'b0;
        idx_d     = idx_q;
        max_d     = max_q;
        best_d    = best_q;
        tie_run_d = tie_run_q;
        winner_d  = winner_q;
        tie_d     = tie_q;
        done_d    = done_q;
        if (clear_i) begin
            busy_d    = 1'b0;
            idx_d     = '0;
            max_d     = '0;
            best_d    = '0;
            tie_run_d = 1'b0;
            winner_d  = '0;
            tie_d     = 1'b0;
            done_d    = 1'b0;
        end else if (start_i) begin
            busy_d    = 1'b1;
            idx_d     = ONE;
            max_d     = '0;
            best_d    = '0;
            tie_run_d = 1'b0;
            winner_d  = '0;
            tie_d     = 1'b0;
            done_d    = 1'b0;
        end else if (busy_q) begin
            if (idx_q == ONE || cur > max_q) begin
                max_d     = cur;
                best_d    = idx_q;
                tie_run_d = 1'b0;
            end else if (cur == max_q) begin
                tie_run_d = 1'b1;
            end
            if (idx_q == LAST) begin
                busy_d = 1'b0;
                fin_d  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (fin_q) begin
            winner_d = best_q;
            tie_d    = tie_run_q;
            done_d   = 1'b1;
        end
    end

    // Scan state registers; reset abandons any scan in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
            idx_q     <= '0;
            max_q     <= '0;
            best_q    <= '0;
            tie_run_q <= 1'b0;
            winner_q  <= '0;
            tie_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            fin_q     <= fin_d;
            idx_q     <= idx_d;
            max_q     <= max_d;
            best_q    <= best_d;
            tie_run_q <= tie_run_d;
            winner_q  <= winner_d;
            tie_q     <= tie_d;
            done_q    <= done_d;
        end
    end

    assign winner_o = winner_q;
    assign tie_o    = tie_q;
    assign done_o   = done_q;
endmodule

// File: rtl/vote_cu_param.sv
// rtl/vote_cu_param.sv - voting control unit: ballot FSM, tallies, readout and winner
module vote_cu_param
    import vote_pkg::*;
#(
    parameter int N_CAND = DEF_N_CAND,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ID_W   = DEF_ID_W
) (
    input  logic             clk,
    input  logic             Power_n,
    vote_cu_param_if.slave   bus
);
    localparam logic [ID_W-1:0]  MAX_CODE = ID_W'(N_CAND);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [2:0]                   state_q, state_d;
    logic                         result_q;
    logic                         lock_q, lock_d;
    logic [N_CAND-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]             total_q, total_d;
    logic [CNT_W-1:0]             out_q, out_d;
    logic                         out_valid_q, out_valid_d;
    logic [ID_W-1:0]              out_idx_q, idx_d;
    logic                         ack_q, ack_d;
    logic                         rej_q, rej_d;
    logic                         accept;
    logic                         result_rise;
    logic                         in_valid;
    logic                         in_over;
    logic                         scan_start;
    logic [CNT_W-1:0]             sel_cnt;

    assign result_rise = bus.Result & ~result_q;
    assign in_valid    = (bus.IN != '0) && (bus.IN <= MAX_CODE);
    assign in_over     = bus.IN > MAX_CODE;
    assign scan_start  = (state_d == S_CLOSED) && (state_q != S_CLOSED);

    // Control FSM; Clear overrides everything, a held Ballot cannot re-arm
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        idx_d   = out_idx_q;
        accept  = 1'b0;
        ack_d   = 1'b0;
        rej_d   = 1'b0;
        if (bus.Clear) begin
            state_d = S_CLEAR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.Ballot) lock_d = 1'b0;
                    if (bus.Close) begin
                        state_d = S_CLOSED;
                    end else if (bus.Ballot && !lock_q) begin
                        state_d = S_ARMED;
                        lock_d  = 1'b1;
                    end else if (bus.Total) begin
                        state_d = S_TOTAL;
                    end
                end
                S_ARMED: begin
                    if (bus.Close) begin
                        state_d = S_CLOSED;
                    end else if (in_valid) begin
                        accept  = 1'b1;
                        ack_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (in_over) begin
                        rej_d = 1'b1;
                    end
                end
                S_TOTAL: begin
                    if (!bus.Total) state_d = S_IDLE;
                end
                S_CLOSED: begin
                    if (result_rise) begin
                        state_d = S_RESULT;
                        idx_d   = ID_W'(1);
                    end
                end
                S_RESULT: begin
                    if (result_rise) begin
                        idx_d = (out_idx_q == MAX_CODE) ? ID_W'(1) : out_idx_q + 1'b1;
                    end
                end
                S_CLEAR: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        if (state_d != S_RESULT) idx_d = '0;
    end

    // Saturating tallies and running total
    always_comb begin
        cnt_d   = cnt_q;
        total_d = total_q;
        if (bus.Clear) begin
            cnt_d   = '0;
            total_d = '0;
        end else if (accept) begin
            for (int k = 0; k < N_CAND; k++) begin
                if (bus.IN == ID_W'(k + 1) && cnt_q[k] != CNT_MAX) cnt_d[k] = cnt_q[k] + 1'b1;
            end
            if (total_q != CNT_MAX) total_d = total_q + 1'b1;
        end
    end

    // Display value for the state being entered
    always_comb begin
        sel_cnt = '0;
        for (int k = 0; k < N_CAND; k++) begin
            if (idx_d == ID_W'(k + 1)) sel_cnt = cnt_q[k];
        end
        out_valid_d = (state_d == S_TOTAL) || (state_d == S_RESULT);
        if (state_d == S_TOTAL)       out_d = total_q;
        else if (state_d == S_RESULT) out_d = sel_cnt;
        else                          out_d = '0;
    end

    // State, tallies and registered outputs
    always_ff @(posedge clk or negedge Power_n) begin
        if (!Power_n) begin
            state_q     <= S_IDLE;
            result_q    <= 1'b0;
            lock_q      <= 1'b0;
            cnt_q       <= '0;
            total_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            ack_q       <= 1'b0;
            rej_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= bus.Result;
            lock_q      <= lock_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= idx_d;
            ack_q       <= ack_d;
            rej_q       <= rej_d;
        end
    end

    vote_winner_scan #(
        .N_CAND (N_CAND),
        .CNT_W  (CNT_W),
        .ID_W   (ID_W)
    ) u_scan (
        .clk      (clk),
        .rst_n    (Power_n),
        .clear_i  (bus.Clear),
        .start_i  (scan_start),
        .cnt_i    (cnt_q),
        .winner_o (bus.winner),
        .tie_o    (bus.tie),
        .done_o   (bus.winner_valid)
    );

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.vote_ack  = ack_q;
    assign bus.reject    = rej_q;
endmodule

// File: tb/tb_vote_cu_param.sv
// tb/tb_vote_cu_param.sv - scoreboard bench for vote_cu_param
module tb_vote_cu_param;
    localparam int N     = 10;
    localparam int CNT_W = 2;
    localparam int ID_W  = 4;

    localparam int K_ACK = 0;
    localparam int K_REJ = 1;
    localparam int K_OUT = 2;
    localparam int K_WIN = 3;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
    } ev_t;

    logic clk = 1'b0;
    logic Power_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    ev_t  exp_q[$];
    logic vld_prev = 1'b0;
    logic wv_prev = 1'b0;
    logic [ID_W-1:0] idx_prev = '0;
    int   tally [11] = '{0, 0, 2, 0, 0, 2, 0, 1, 0, 0, 1};

    vote_cu_param_if #(.CNT_W(CNT_W), .ID_W(ID_W)) bus ();

    vote_cu_param #(.N_CAND(N), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
        .clk     (clk),
        .Power_n (Power_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int a, input int b, input int c);
        ev_t e;
        e.kind = kind;
        e.a = a;
        e.b = b;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input int a, input int b, input int c);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d a %0d b %0d expected none", kind, a, b);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (e.kind == kind && kind == K_OUT) begin
                check("out_idx", a, e.a);
                check("out_value", b, e.b);
            end
            if (e.kind == kind && kind == K_WIN) begin
                check("winner", a, e.a);
                check("tie", b, e.b);
                check("winner_valid_cycle", c, e.c);
            end
        end
    endtask

    // Monitor: every presented response is matched against the scoreboard
    always @(negedge clk) begin
        if (bus.vote_ack) expect_ev(K_ACK, 0, 0, 0);
        if (bus.reject) expect_ev(K_REJ, 0, 0, 0);
        if (bus.out_valid && (!vld_prev || bus.out_idx != idx_prev))
            expect_ev(K_OUT, int'(bus.out_idx), int'(bus.out), 0);
        if (bus.winner_valid && !wv_prev)
            expect_ev(K_WIN, int'(bus.winner), int'(bus.tie), cyc);
        vld_prev <= bus.out_valid;
        idx_prev <= bus.out_idx;
        wv_prev  <= bus.winner_valid;
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out"}, int'(bus.out), 0);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check({tag, "_out_idx"}, int'(bus.out_idx), 0);
    endtask

    task automatic check_cleared(input string tag);
        check_idle_outputs(tag);
        check({tag, "_winner"}, int'(bus.winner), 0);
        check({tag, "_tie"}, int'(bus.tie), 0);
        check({tag, "_winner_valid"}, int'(bus.winner_valid), 0);
        check({tag, "_vote_ack"}, int'(bus.vote_ack), 0);
    endtask

    task automatic vote(input int code);
        bus.Ballot = 1'b1;
        bus.IN = ID_W'(code);
        push(K_ACK, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        bus.Ballot = 1'b0;
        bus.IN = '0;
        @(negedge clk);
    endtask

    task automatic show_total(input int exp);
        bus.Total = 1'b1;
        push(K_OUT, 0, exp, 0);
        @(negedge clk);
        @(negedge clk);
        bus.Total = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_total");
    endtask

    task automatic do_clear();
        bus.Clear = 1'b1;
        @(negedge clk);
        check_cleared("clear");
        @(negedge clk);
        bus.Clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic close_expect(input int w, input int t);
        bus.Close = 1'b1;
        push(K_WIN, w, t, cyc + N + 2);
        @(negedge clk);
        bus.Close = 1'b0;
        bus.Ballot = 1'b1;
        bus.IN = ID_W'(3);
        @(negedge clk);
        @(negedge clk);
        bus.Ballot = 1'b0;
        bus.IN = '0;
        repeat (N + 1) @(negedge clk);
        check("winner_valid_held", int'(bus.winner_valid), 1);
    endtask

    task automatic result_pulse(input int idx, input int val, input int width);
        bus.Result = 1'b1;
        push(K_OUT, idx, val, 0);
        repeat (width) @(negedge clk);
        bus.Result = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.Close = 1'b0;
        bus.Clear = 1'b0;
        bus.Ballot = 1'b0;
        bus.Total = 1'b0;
        bus.Result = 1'b0;
        bus.IN = '0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        check("reset_reject", int'(bus.reject), 0);
        Power_n = 1'b1;
        @(negedge clk);

        vote(3);
        show_total(1);

        bus.Ballot = 1'b1;
        bus.IN = ID_W'(15);
        push(K_REJ, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        bus.IN = '0;
        @(negedge clk);
        bus.IN = ID_W'(2);
        push(K_ACK, 0, 0, 0);
        @(negedge clk);
        bus.Ballot = 1'b0;
        bus.IN = '0;
        @(negedge clk);
        show_total(2);

        bus.Ballot = 1'b1;
        bus.IN = ID_W'(4);
        push(K_ACK, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        repeat (3) @(negedge clk);
        bus.Ballot = 1'b0;
        bus.IN = '0;
        @(negedge clk);
        show_total(3);
        vote(6);
        show_total(3);

        do_clear();
        for (int i = 0; i < 5; i++) vote(1);
        show_total(3);
        close_expect(1, 0);
        result_pulse(1, 3, 1);
        result_pulse(2, 0, 1);

        do_clear();
        bus.Ballot = 1'b1;
        bus.IN = ID_W'(4);
        @(negedge clk);
        bus.Clear = 1'b1;
        @(negedge clk);
        check_cleared("clear_in_armed");
        bus.Clear = 1'b0;
        bus.Ballot = 1'b0;
        bus.IN = '0;
        @(negedge clk);
        show_total(0);

        vote(2);
        vote(2);
        vote(5);
        vote(5);
        vote(7);
        vote(10);
        show_total(3);
        close_expect(2, 1);
        for (int p = 0; p <= N; p++) begin
            bus.Close = p[0];
            result_pulse((p % N) + 1, tally[(p % N) + 1], (p == 3) ? 3 : 1);
        end
        bus.Close = 1'b0;

        do_clear();
        close_expect(1, 1);

        do_clear();
        vote(4);
        bus.Close = 1'b1;
        @(negedge clk);
        bus.Close = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        Power_n = 1'b0;
        #1;
        check_cleared("async_reset");
        @(negedge clk);
        Power_n = 1'b1;
        @(negedge clk);
        show_total(0);
        close_expect(1, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
